// File: rtl/playbus_seq.sv
// Shared-bus sequencer: ROM/RAM/switch sources feed RAM and per-digit LED
// latches through one bus, driven by a valid/ready command FSM.
module playbus_seq #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int N_DIGITS = 2,
  parameter int DIG_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  n_clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DIG_W-1:0]      cmd_digit,
  input  logic [DATA_W-1:0]     sw,
  output logic                  ROMO,
  output logic                  RAMO,
  output logic                  SWBEN,
  output logic                  RAMW,
  output logic                  LEDLTCH,
  output logic [DATA_W-1:0]     bus,
  output logic                  done,
  output logic [7*N_DIGITS-1:0] disp
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] OP_SW_RAM  = 2'b00;
  localparam logic [1:0] OP_ROM_RAM = 2'b01;
  localparam logic [1:0] OP_RAM_LED = 2'b10;
  localparam logic [1:0] OP_SW_LED  = 2'b11;

  typedef enum logic [1:0] {
    IDLE, DRIVE, STROBE, DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [DATA_W-1:0] bus_q, bus_d;

  logic [DATA_W-1:0] ram_q [DEPTH];
  logic [DATA_W-1:0] ram_d [DEPTH];
  logic [DATA_W-1:0] lat_q [N_DIGITS];
  logic [DATA_W-1:0] lat_d [N_DIGITS];
  logic [N_DIGITS-1:0] blank_q, blank_d;

  logic              sel_sw, sel_rom, sel_ram, to_led;
  logic [DATA_W-1:0] rom_v, src;

  // 3*a mod 2**DATA_W; truncating a first is equivalent modulo 2**DATA_W
  assign rom_v = DATA_W'(addr_q) * DATA_W'(3);

  always_comb begin
    sel_sw  = (op_q == OP_SW_RAM) || (op_q == OP_SW_LED);
    sel_rom = (op_q == OP_ROM_RAM);
    sel_ram = (op_q == OP_RAM_LED);
    to_led  = op_q[1];
    src     = '0;
    unique case (1'b1)
      sel_sw:  src = sw;
      sel_rom: src = rom_v;
      sel_ram: src = ram_q[addr_q];
      default: src = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    digit_d   = digit_q;
    bus_d     = bus_q;
    ram_d     = ram_q;
    lat_d     = lat_q;
    blank_d   = blank_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    ROMO      = 1'b0;
    RAMO      = 1'b0;
    SWBEN     = 1'b0;
    RAMW      = 1'b0;
    LEDLTCH   = 1'b0;
    bus       = bus_q;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          digit_d = cmd_digit;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        SWBEN   = sel_sw;
        ROMO    = sel_rom;
        RAMO    = sel_ram;
        bus     = src;
        bus_d   = src;
        state_d = STROBE;
      end
      STROBE: begin
        SWBEN   = sel_sw;
        ROMO    = sel_rom;
        RAMO    = sel_ram;
        RAMW    = !to_led;
        LEDLTCH = to_led;
        bus     = src;
        bus_d   = src;
        if (!to_led) begin
          ram_d[addr_q] = src;
        end else begin
          // out-of-range digits strobe but match no latch
          for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_q == DIG_W'(i)) begin
              lat_d[i]   = src;
              blank_d[i] = 1'b0;
            end
          end
        end
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge n_clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      digit_q <= '0;
      bus_q   <= '0;
      blank_q <= '1;
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
      for (int i = 0; i < N_DIGITS; i++) lat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      digit_q <= digit_d;
      bus_q   <= bus_d;
      blank_q <= blank_d;
      ram_q   <= ram_d;
      lat_q   <= lat_d;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    disp = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      disp[7*i +: 7] = blank_q[i] ? 7'h7F : hex7(lat_q[i][3:0]);
    end
  end

endmodule

// File: tb/tb_playbus_seq.sv
// Bench for playbus_seq: command table, directed corner sequences and
// random traffic checked each cycle against a transaction-level model.
module tb_playbus_seq;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int ND = 3;
  localparam int GW = 2;

  logic            n_clk = 1'b1;
  logic            reset = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [1:0]      cmd_op = '0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [GW-1:0]   cmd_digit = '0;
  logic [DW-1:0]   sw = '0;
  logic            ROMO, RAMO, SWBEN, RAMW, LEDLTCH, done;
  logic [DW-1:0]   bus;
  logic [7*ND-1:0] disp;

  playbus_seq #(.DATA_W(DW), .ADDR_W(AW), .N_DIGITS(ND)) dut (
    .n_clk(n_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_digit(cmd_digit),
    .sw(sw), .ROMO(ROMO), .RAMO(RAMO), .SWBEN(SWBEN),
    .RAMW(RAMW), .LEDLTCH(LEDLTCH), .bus(bus),
    .done(done), .disp(disp)
  );

  always #5 n_clk = ~n_clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                           7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  // model: phase 0 idle, 1..3 = cycles since command accepted
  int          m_ph;
  logic [1:0]  m_op;
  int          m_addr, m_dig;
  logic [DW-1:0] m_ram [16];
  logic [DW-1:0] m_lat [ND];
  bit          m_blank [ND];
  logic [DW-1:0] m_bus;

  int c_en, c_str, c_done, c_nrdy;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_src();
    if (m_op == 2'd1) return DW'((3 * m_addr) % (1 << DW));
    if (m_op == 2'd2) return m_ram[m_addr];
    return sw;
  endfunction

  function automatic logic [7*ND-1:0] m_disp();
    logic [7*ND-1:0] r;
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = m_blank[i] ? 7'h7F : seg[m_lat[i]];
    return r;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_op = 0; m_addr = 0; m_dig = 0; m_bus = '0;
    for (int i = 0; i < 16; i++) m_ram[i] = '0;
    for (int i = 0; i < ND; i++) begin
      m_lat[i] = '0;
      m_blank[i] = 1'b1;
    end
  endtask

  task automatic check_cycle();
    bit act;
    act = (m_ph == 1) || (m_ph == 2);
    chk("cmd_ready", 32'(cmd_ready), 32'(m_ph == 0));
    chk("done", 32'(done), 32'(m_ph == 3));
    chk("SWBEN", 32'(SWBEN), 32'(act && (m_op == 0 || m_op == 3)));
    chk("ROMO", 32'(ROMO), 32'(act && m_op == 1));
    chk("RAMO", 32'(RAMO), 32'(act && m_op == 2));
    chk("RAMW", 32'(RAMW), 32'(m_ph == 2 && !m_op[1]));
    chk("LEDLTCH", 32'(LEDLTCH), 32'(m_ph == 2 && m_op[1]));
    chk("bus", 32'(bus), 32'(act ? m_src() : m_bus));
    chk("disp", 32'(disp), 32'(m_disp()));
    chk("src_onehot", 32'(int'(ROMO) + int'(RAMO) + int'(SWBEN) <= 1), 32'd1);
  endtask

  task automatic model_edge();
    logic [DW-1:0] v;
    case (m_ph)
      0: if (cmd_valid) begin
        m_op = cmd_op; m_addr = int'(cmd_addr); m_dig = int'(cmd_digit);
        m_ph = 1;
      end
      1: begin m_bus = m_src(); m_ph = 2; end
      2: begin
        v = m_src();
        m_bus = v;
        if (!m_op[1]) m_ram[m_addr] = v;
        else if (m_dig < ND) begin
          m_lat[m_dig] = v;
          m_blank[m_dig] = 1'b0;
        end
        m_ph = 3;
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic cycle();
    @(posedge n_clk);
    #1;
    check_cycle();
    c_en   += int'(ROMO | RAMO | SWBEN);
    c_str  += int'(RAMW | LEDLTCH);
    c_done += int'(done);
    c_nrdy += int'(!cmd_ready);
    model_edge();
    @(negedge n_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] a,
                       input logic [1:0] d, input logic [3:0] s);
    c_en = 0; c_str = 0; c_done = 0; c_nrdy = 0;
    cmd_op = op; cmd_addr = a; cmd_digit = d; sw = s;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("seq_enable_cycles", 32'(c_en), 32'd2);
    chk("seq_strobe_cycles", 32'(c_str), 32'd1);
    chk("seq_done_cycles", 32'(c_done), 32'd1);
    chk("seq_ready_low", 32'(c_nrdy), 32'd3);
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [3:0]      addr;
    logic [1:0]      dig;
    logic [3:0]      sw;
    logic [7*ND-1:0] disp;
  } vec_t;

  vec_t tbl [7];

  int acc, dn, last_acc, gap_bad;

  initial begin
    tbl[0] = '{2'd3, 4'h0, 2'd0, 4'hA, {7'h7F, 7'h7F, 7'h08}};
    tbl[1] = '{2'd0, 4'h3, 2'd0, 4'h5, {7'h7F, 7'h7F, 7'h08}};
    tbl[2] = '{2'd2, 4'h3, 2'd1, 4'h0, {7'h7F, 7'h12, 7'h08}};
    tbl[3] = '{2'd1, 4'h2, 2'd0, 4'h0, {7'h7F, 7'h12, 7'h08}};
    tbl[4] = '{2'd2, 4'h2, 2'd0, 4'h0, {7'h7F, 7'h12, 7'h02}};
    tbl[5] = '{2'd3, 4'h0, 2'd3, 4'h9, {7'h7F, 7'h12, 7'h02}};
    tbl[6] = '{2'd3, 4'h0, 2'd2, 4'h9, {7'h10, 7'h12, 7'h02}};

    model_reset();
    @(negedge n_clk);
    #1;
    check_cycle();
    chk("reset_disp", 32'(disp), 32'h1FFFFF);
    chk("reset_bus", 32'(bus), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      issue(tbl[i].op, tbl[i].addr, tbl[i].dig, tbl[i].sw);
      chk($sformatf("tbl%0d_disp", i), 32'(disp), 32'(tbl[i].disp));
    end

    // continuous valid: one accept per 4 cycles
    acc = 0; dn = 0; last_acc = -4; gap_bad = 0; c_done = 0;
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_digit = 2'd1; sw = 4'h3;
    for (int k = 0; k < 12; k++) begin
      if (cmd_ready) begin
        acc++;
        if (k - last_acc != 4) gap_bad++;
        last_acc = k;
      end
      cycle();
    end
    cmd_valid = 1'b0;
    chk("stream_accepts", 32'(acc), 32'd3);
    chk("stream_dones", 32'(c_done), 32'd3);
    chk("stream_gap", 32'(gap_bad), 32'd0);

    // reset pulsed while the RAM write is strobing
    cmd_op = 2'd0; cmd_addr = 4'hF; sw = 4'h9; cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    cycle();
    @(posedge n_clk);
    #1;
    check_cycle();
    chk("strobe_ramw", 32'(RAMW), 32'd1);
    reset = 1'b1;
    #1;
    model_reset();
    check_cycle();
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_disp", 32'(disp), 32'h1FFFFF);
    #1;
    reset = 1'b0;
    @(negedge n_clk);
    #1;
    issue(2'd2, 4'hF, 2'd0, 4'h9);
    chk("rst_ram_f", 32'(disp), 32'({7'h7F, 7'h7F, 7'h40}));

    // random traffic against the model, with occasional resets
    for (int k = 0; k < 400; k++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom);
      cmd_addr  = 4'($urandom);
      cmd_digit = 2'($urandom);
      sw        = 4'($urandom);
      if ($urandom_range(0, 60) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_cycle();
        reset = 1'b0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
